// File: rtl/router_pkt_tx_if.sv
// Write/start/router bus between a packet source and router_pkt_tx.
// corrupt_parity exists only when ROUTER_PKT_TX_ERR_INJ_EN is defined.
interface router_pkt_tx_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic       busy;
    logic       packet_valid;
    logic [7:0] data_out;
    logic       tx_active;
    logic       done;
    logic       len_err;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
    logic       corrupt_parity;
`endif

    modport master (
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
        output corrupt_parity,
`endif
        output wr_en, wr_data, start, dest_addr, pay_len, busy,
        input  wr_ready, packet_valid, data_out, tx_active, done, len_err
    );

    modport slave (
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
        input  corrupt_parity,
`endif
        input  wr_en, wr_data, start, dest_addr, pay_len, busy,
        output wr_ready, packet_valid, data_out, tx_active, done, len_err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Buffered packet transmitter: header, payload, XOR parity, then MIN_GAP idle cycles.
// Optional parity error injection under macro ROUTER_PKT_TX_ERR_INJ_EN.
module router_pkt_tx #(
    parameter int MIN_GAP = 2
) (
    input  logic           clk,
    input  logic           resetn,
    router_pkt_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;

    state_t     state_reg, state_next;
    logic [5:0] count_reg, count_next;
    logic [5:0] wr_ptr_reg, wr_ptr_next;
    logic [5:0] rd_ptr_reg, rd_ptr_next;
    logic [5:0] len_reg, len_next;
    logic [7:0] parity_reg, parity_next;
    logic [7:0] data_out_reg, data_out_next;
    logic [3:0] gap_reg, gap_next;
    logic       pv_reg, pv_next;
    logic       done_reg, done_next;
    logic       len_err_reg, len_err_next;
    logic       tx_active_reg, tx_active_next;
    logic       wr_ready_reg, wr_ready_next;

    logic [7:0] mem [0:63];
    logic [7:0] rd_data_reg;
    logic       wr_fire;
    logic       start_ok;
    logic [7:0] parity_tx;

`ifdef ROUTER_PKT_TX_ERR_INJ_EN
    logic corrupt_reg, corrupt_next;
    assign parity_tx = parity_reg ^ {7'b0, corrupt_reg};
`else
    assign parity_tx = parity_reg;
`endif

    assign wr_fire  = (state_reg == IDLE) && bus.wr_en && wr_ready_reg;
    assign start_ok = (bus.pay_len != 6'd0) && (bus.pay_len <= count_reg) &&
                      (bus.dest_addr != 2'd3);

    // rd_data_reg always holds mem[rd_ptr_reg]: the read address runs one step ahead.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_ptr_reg] <= bus.wr_data;
        rd_data_reg <= mem[rd_ptr_next];
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        len_next      = len_reg;
        parity_next   = parity_reg;
        data_out_next = data_out_reg;
        gap_next      = gap_reg;
        pv_next       = pv_reg;
        done_next     = 1'b0;
        len_err_next  = 1'b0;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
        corrupt_next  = corrupt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (wr_fire) begin
                    count_next  = count_reg + 6'd1;
                    wr_ptr_next = wr_ptr_reg + 6'd1;
                end
                if (bus.start) begin
                    if (start_ok) begin
                        state_next    = HEADER;
                        pv_next       = 1'b1;
                        data_out_next = {bus.pay_len, bus.dest_addr};
                        parity_next   = {bus.pay_len, bus.dest_addr};
                        len_next      = bus.pay_len;
                        rd_ptr_next   = 6'd0;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
                        corrupt_next  = bus.corrupt_parity;
`endif
                    end else begin
                        len_err_next = 1'b1;
                    end
                end
            end
            HEADER: begin
                if (!bus.busy) begin
                    state_next    = PAYLOAD;
                    data_out_next = rd_data_reg;
                    parity_next   = parity_reg ^ rd_data_reg;
                    rd_ptr_next   = rd_ptr_reg + 6'd1;
                end
            end
            PAYLOAD: begin
                if (!bus.busy) begin
                    // rd_ptr equals len once the last payload byte is on the bus
                    if (rd_ptr_reg == len_reg) begin
                        state_next    = PARITY;
                        pv_next       = 1'b0;
                        data_out_next = parity_tx;
                    end else begin
                        data_out_next = rd_data_reg;
                        parity_next   = parity_reg ^ rd_data_reg;
                        rd_ptr_next   = rd_ptr_reg + 6'd1;
                    end
                end
            end
            PARITY: begin
                if (!bus.busy) begin
                    state_next    = GAP;
                    data_out_next = 8'd0;
                    done_next     = 1'b1;
                    gap_next      = 4'd0;
                end
            end
            GAP: begin
                if (gap_reg == 4'(MIN_GAP - 1)) begin
                    state_next  = IDLE;
                    count_next  = 6'd0;
                    wr_ptr_next = 6'd0;
                    rd_ptr_next = 6'd0;
                end else begin
                    gap_next = gap_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        tx_active_next = (state_next != IDLE);
        wr_ready_next  = (state_next == IDLE) && (count_next != 6'd63);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            count_reg     <= 6'd0;
            wr_ptr_reg    <= 6'd0;
            rd_ptr_reg    <= 6'd0;
            len_reg       <= 6'd0;
            parity_reg    <= 8'd0;
            data_out_reg  <= 8'd0;
            gap_reg       <= 4'd0;
            pv_reg        <= 1'b0;
            done_reg      <= 1'b0;
            len_err_reg   <= 1'b0;
            tx_active_reg <= 1'b0;
            wr_ready_reg  <= 1'b0;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
            corrupt_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            len_reg       <= len_next;
            parity_reg    <= parity_next;
            data_out_reg  <= data_out_next;
            gap_reg       <= gap_next;
            pv_reg        <= pv_next;
            done_reg      <= done_next;
            len_err_reg   <= len_err_next;
            tx_active_reg <= tx_active_next;
            wr_ready_reg  <= wr_ready_next;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
            corrupt_reg   <= corrupt_next;
`endif
        end
    end

    assign bus.packet_valid = pv_reg;
    assign bus.data_out     = data_out_reg;
    assign bus.done         = done_reg;
    assign bus.len_err      = len_err_reg;
    assign bus.tx_active    = tx_active_reg;
    assign bus.wr_ready     = wr_ready_reg;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed and random packets against a byte-queue model.
`timescale 1ns/1ps
module tb_router_pkt_tx;
    localparam int MIN_GAP = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    router_pkt_tx_if bus();
    router_pkt_tx #(.MIN_GAP(MIN_GAP)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] buf_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        check("wr_ready", 32'(bus.wr_ready), 32'(buf_q.size() < 63));
        bus.wr_en = 1'b1;
        bus.wr_data = b;
        step();
        bus.wr_en = 1'b0;
        if (buf_q.size() < 63) buf_q.push_back(b);
        $display("write 0x%02h -> model count %0d", b, buf_q.size());
    endtask

    // Stream is header, payload[0..len-1], parity (header XOR payload); busy stalls.
    task automatic send(input int dest, input int len, input int busy_pct,
                        input int hold_idx, input bit with_wr, input bit corrupt);
        bit ok;
        bit b;
        bit cp_eff;
        int idx;
        int holds;
        int cycles;
        logic [7:0] wd;
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] exp_q[$];
        ok = (len != 0) && (len <= buf_q.size()) && (dest != 3);
        wd = 8'($urandom);
        hdr = {6'(len), 2'(dest)};
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
        cp_eff = corrupt;
        bus.corrupt_parity = corrupt;
`else
        cp_eff = 1'b0;
        if (corrupt) $display("note: parity injection not built in");
`endif
        bus.start = 1'b1;
        bus.dest_addr = 2'(dest);
        bus.pay_len = 6'(len);
        if (with_wr) begin
            bus.wr_en = 1'b1;
            bus.wr_data = wd;
        end
        step();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        if (with_wr && buf_q.size() < 63) buf_q.push_back(wd);
        check("start_resp", 32'({bus.len_err, bus.tx_active}), 32'({!ok, ok}));
        if (!ok) begin
            step();
            check("len_err_pulse", 32'({bus.len_err, bus.tx_active}), 32'(0));
            $display("start dest=%0d len=%0d rejected, model count %0d", dest, len, buf_q.size());
            return;
        end
        par = hdr;
        exp_q.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(buf_q[i]);
            par ^= buf_q[i];
        end
        exp_q.push_back(par ^ {7'b0, cp_eff});
        idx = 0;
        holds = 0;
        cycles = 0;
        while (idx < len + 2) begin
            check("stream",
                  32'({bus.packet_valid, bus.data_out, bus.done, bus.tx_active, bus.len_err, bus.wr_ready}),
                  32'({idx <= len, exp_q[idx], 1'b0, 1'b1, 1'b0, 1'b0}));
            if (idx == hold_idx && holds < 3) begin
                b = 1'b1;
                holds++;
            end else begin
                b = (int'($urandom_range(99)) < busy_pct);
            end
            bus.busy = b;
            bus.start = 1'($urandom_range(1));
            bus.dest_addr = 2'd3;
            bus.pay_len = 6'($urandom);
            bus.wr_en = 1'($urandom_range(1));
            step();
            if (!b) idx++;
            cycles++;
            if (cycles > 4000) begin
                check("stream_timeout", 32'(idx), 32'(len + 2));
                break;
            end
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check("done_gap", 32'({bus.packet_valid, bus.data_out, bus.done, bus.tx_active, bus.len_err}),
              32'({1'b0, 8'd0, 1'b1, 1'b1, 1'b0}));
        for (int g = 1; g < MIN_GAP; g++) begin
            bus.busy = 1'($urandom_range(1));
            step();
            check("gap", 32'({bus.packet_valid, bus.data_out, bus.done, bus.tx_active, bus.len_err}),
                  32'({1'b0, 8'd0, 1'b0, 1'b1, 1'b0}));
        end
        bus.busy = 1'($urandom_range(1));
        step();
        bus.busy = 1'b0;
        check("back_idle", 32'({bus.packet_valid, bus.done, bus.tx_active, bus.wr_ready}), 32'(4'b0001));
        buf_q.delete();
        $display("packet dest=%0d len=%0d parity=0x%02h sent in %0d cycles", dest, len, exp_q[len + 1], cycles);
    endtask

    initial begin
        int nb;
        int ln;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'd0;
        bus.start = 1'b0;
        bus.dest_addr = 2'd0;
        bus.pay_len = 6'd0;
        bus.busy = 1'b0;
`ifdef ROUTER_PKT_TX_ERR_INJ_EN
        bus.corrupt_parity = 1'b0;
`endif
        step();
        step();
        check("reset_outs", 32'({bus.packet_valid, bus.data_out, bus.done, bus.len_err, bus.tx_active}), 32'(0));
        #2 resetn = 1'b1;
        step();
        check("reset_release", 32'({bus.wr_ready, bus.tx_active}), 32'(2'b10));

        // basic three-byte packet
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        send(1, 3, 0, -1, 1'b0, 1'b0);

        // same packet, 0x22 stalled for three cycles
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        send(1, 3, 0, 2, 1'b0, 1'b0);

        // rejected starts keep the buffer
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        send(1, 5, 0, -1, 1'b0, 1'b0);
        send(3, 3, 0, -1, 1'b0, 1'b0);
        send(0, 0, 0, -1, 1'b0, 1'b0);
        send(1, 3, 20, -1, 1'b0, 1'b0);

        // start with a simultaneous write validates against the old count
        wr_byte(8'hA5); wr_byte(8'h5A);
        send(2, 3, 0, -1, 1'b1, 1'b0);
        send(2, 3, 0, -1, 1'b0, 1'b0);

        // full buffer
        for (int i = 0; i < 63; i++) wr_byte(8'hFF);
        wr_byte(8'h00);
        send(2, 63, 10, -1, 1'b0, 1'b0);

        // parity injection
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        send(1, 3, 0, -1, 1'b0, 1'b1);

        // reset in the middle of the payload
        for (int i = 0; i < 5; i++) wr_byte(8'(8'h40 + i));
        bus.start = 1'b1; bus.dest_addr = 2'd0; bus.pay_len = 6'd5;
        step();
        bus.start = 1'b0;
        step();
        step();
        #2 resetn = 1'b0;
        #1;
        check("reset_abort", 32'({bus.packet_valid, bus.data_out, bus.tx_active, bus.done}), 32'(0));
        step();
        check("reset_hold", 32'({bus.packet_valid, bus.data_out, bus.tx_active, bus.done}), 32'(0));
        #2 resetn = 1'b1;
        step();
        check("reset_after", 32'({bus.tx_active, bus.done, bus.wr_ready}), 32'(3'b001));
        step();
        check("no_done", 32'(bus.done), 32'(0));
        buf_q.delete();
        $display("reset during payload: packet aborted");
        wr_byte(8'h01); wr_byte(8'h80);
        send(0, 2, 0, -1, 1'b0, 1'b0);

        // random traffic
        for (int p = 0; p < 15; p++) begin
            nb = int'($urandom_range(1, 63));
            for (int i = 0; i < nb; i++) wr_byte(8'($urandom));
            ln = int'($urandom_range(0, 63));
            if ($urandom_range(3) != 0 && ln > buf_q.size()) ln = buf_q.size();
            send(int'($urandom_range(0, 3)), ln, 30, -1, 1'($urandom_range(1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
